// File: rtl/maze_collision_probe.sv
// Scans a BOX_W x BOX_H footprint through the maze ROM and reports wall hits.
// Latency: start-to-done is BOX_W*BOX_H+2 cycles; start is ignored while a scan is in flight.
module maze_collision_probe #(
    parameter int          WIDTH      = 96,
    parameter int          HEIGHT     = 64,
    parameter int          BOX_W      = 3,
    parameter int          BOX_H      = 3,
    parameter logic [15:0] WALL_COLOR = 16'hFFFF,
    parameter int          IDX_W      = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       pos_x,
    input  logic [5:0]       pos_y,
    output logic [IDX_W-1:0] maze_index,
    input  logic [15:0]      maze_data,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [6:0]       hit_x,
    output logic [5:0]       hit_y,
    output logic [6:0]       hit_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [2:0] CX_LAST = 3'(BOX_W - 1);
    localparam logic [2:0] CY_LAST = 3'(BOX_H - 1);
    localparam logic [7:0] X_LIM   = 8'(WIDTH);
    localparam logic [6:0] Y_LIM   = 7'(HEIGHT);

    state_t           state;
    logic [6:0]       base_x;
    logic [5:0]       base_y;
    logic [2:0]       cx, cy;
    logic [2:0]       nx_c, ny_c;
    logic             last_px;
    logic [7:0]       px_x;
    logic [6:0]       px_y;
    logic             px_inb;
    logic [IDX_W-1:0] px_idx;
    logic [6:0]       pres_x, ev_x;
    logic [5:0]       pres_y, ev_y;
    logic             pres_inb, ev_inb, ev_vld;
    logic             ev_wall;

    // (cx, cy) is the pixel currently on maze_index; px_* is the one registered next.
    always_comb begin
        last_px = (cx == CX_LAST) && (cy == CY_LAST);
        nx_c    = cx + 3'd1;
        ny_c    = cy;
        if (cx == CX_LAST) begin
            nx_c = '0;
            ny_c = cy + 3'd1;
        end
        if (state == IDLE) begin
            px_x = {1'b0, pos_x};
            px_y = {1'b0, pos_y};
        end else begin
            px_x = {1'b0, base_x} + {5'b0, nx_c};
            px_y = {1'b0, base_y} + {4'b0, ny_c};
        end
        px_inb  = (px_x < X_LIM) && (px_y < Y_LIM);
        px_idx  = IDX_W'(32'(px_y) * 32'(WIDTH) + 32'(px_x));
        ev_wall = !ev_inb || (maze_data == WALL_COLOR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base_x     <= '0;
            base_y     <= '0;
            cx         <= '0;
            cy         <= '0;
            maze_index <= '0;
            pres_x     <= '0;
            pres_y     <= '0;
            pres_inb   <= 1'b0;
            ev_x       <= '0;
            ev_y       <= '0;
            ev_inb     <= 1'b0;
            ev_vld     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hit        <= 1'b0;
            hit_x      <= '0;
            hit_y      <= '0;
            hit_count  <= '0;
        end else begin
            done   <= 1'b0;
            ev_vld <= 1'b0;
            if (ev_vld && ev_wall) begin
                if (hit_count != 7'h7F) hit_count <= hit_count + 7'd1;
                if (!hit) begin
                    hit   <= 1'b1;
                    hit_x <= ev_x;
                    hit_y <= ev_y;
                end
            end
            case (state)
                IDLE: if (start) begin
                    base_x    <= pos_x;
                    base_y    <= pos_y;
                    cx        <= '0;
                    cy        <= '0;
                    hit       <= 1'b0;
                    hit_x     <= '0;
                    hit_y     <= '0;
                    hit_count <= '0;
                    busy      <= 1'b1;
                    if (px_inb) maze_index <= px_idx;
                    pres_x    <= px_x[6:0];
                    pres_y    <= px_y[5:0];
                    pres_inb  <= px_inb;
                    state     <= SCAN;
                end
                SCAN: begin
                    // The presented pixel's data arrives next cycle, alongside this copy.
                    ev_vld <= 1'b1;
                    ev_x   <= pres_x;
                    ev_y   <= pres_y;
                    ev_inb <= pres_inb;
                    if (last_px) begin
                        state <= DRAIN;
                    end else begin
                        cx       <= nx_c;
                        cy       <= ny_c;
                        if (px_inb) maze_index <= px_idx;
                        pres_x   <= px_x[6:0];
                        pres_y   <= px_y[5:0];
                        pres_inb <= px_inb;
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_collision_probe.sv
// Scoreboard bench: stimulus queues expected indices and results, monitors compare on negedge.
module tb_maze_collision_probe;

    typedef struct {
        int hit;
        int hx;
        int hy;
        int cnt;
        int dcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  pos_x = '0;
    logic [5:0]  pos_y = '0;
    logic [12:0] maze_index;
    logic [15:0] maze_data = '0;
    logic        busy, done, hit;
    logic [6:0]  hit_x, hit_count;
    logic [5:0]  hit_y;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int scan_k = 0;
    exp_t res_q[$];
    int   idx_q[$];

    logic        ovr_en = 1'b0;
    logic [12:0] ovr_idx = '0;
    logic [15:0] ovr_val = '0;

    int t_floor[9] = '{970, 971, 972, 1066, 1067, 1068, 1162, 1163, 1164};
    int t_left[9]  = '{1921, 1922, 1923, 2017, 2018, 2019, 2113, 2114, 2115};
    int t_oob[9]   = '{6143, 6143, 6143, 6143, 6143, 6143, 6143, 6143, 6143};

    maze_collision_probe dut (
        .clk(clk), .reset(reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .maze_index(maze_index), .maze_data(maze_data), .busy(busy), .done(done),
        .hit(hit), .hit_x(hit_x), .hit_y(hit_y), .hit_count(hit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_val(input logic [12:0] idx);
        int x, y;
        x = int'(idx) % 96;
        y = int'(idx) / 96;
        if (ovr_en && idx == ovr_idx) return ovr_val;
        if (x <= 2 || x >= 93 || y <= 2 || y >= 61) return 16'hFFFF;
        return 16'h0000;
    endfunction

    always @(posedge clk) maze_data <= rom_val(maze_index);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset || !busy) begin
            scan_k = 0;
        end else begin
            if (scan_k < 9 && idx_q.size() > 0) check("maze_index", int'(maze_index), idx_q.pop_front());
            scan_k++;
        end
        if (done) begin
            if (res_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = res_q.pop_front();
                check("done_cycle", cyc, e.dcyc);
                check("hit", int'(hit), e.hit);
                check("hit_x", int'(hit_x), e.hx);
                check("hit_y", int'(hit_y), e.hy);
                check("hit_count", int'(hit_count), e.cnt);
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic issue(input int px, input int py, input int ehit, input int ehx,
                         input int ehy, input int ecnt, input int idx[9]);
        exp_t e;
        @(posedge clk); #1;
        pos_x = 7'(px);
        pos_y = 6'(py);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e.hit = ehit; e.hx = ehx; e.hy = ehy; e.cnt = ecnt; e.dcyc = cyc + 10;
        res_q.push_back(e);
        for (int i = 0; i < 9; i++) idx_q.push_back(idx[i]);
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (res_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (res_q.size() != 0) begin
            check("done_timeout", 0, 1);
            res_q.delete();
            idx_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_index", int'(maze_index), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_count", int'(hit_count), 0);
        reset = 1'b0;

        issue(10, 10, 0, 0, 0, 0, t_floor);
        wait_idle();

        issue(1, 20, 1, 1, 20, 6, t_left);
        wait_idle();

        issue(95, 63, 1, 95, 63, 9, t_oob);
        wait_idle();

        ovr_en = 1'b1; ovr_idx = 13'd1067; ovr_val = 16'h001F;
        issue(10, 10, 0, 0, 0, 0, t_floor);
        wait_idle();
        ovr_val = 16'hFFFF;
        issue(10, 10, 1, 11, 11, 1, t_floor);
        wait_idle();
        ovr_en = 1'b0;

        // A second start mid-scan must not queue a second probe.
        issue(10, 10, 0, 0, 0, 0, t_floor);
        repeat (3) @(posedge clk);
        #1;
        pos_x = 7'd1; pos_y = 6'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (10) @(posedge clk);

        // Reset part-way through a scan aborts it without a done pulse.
        @(posedge clk); #1;
        pos_x = 7'd1; pos_y = 6'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_hit", int'(hit), 1);
        check("pre_reset_count", int'(hit_count), 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_hit", int'(hit), 0);
        check("abort_count", int'(hit_count), 0);
        check("abort_done", int'(done), 0);
        repeat (15) @(posedge clk);

        issue(10, 10, 0, 0, 0, 0, t_floor);
        wait_idle();

        check("res_q_empty", res_q.size(), 0);
        check("idx_q_empty", idx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maze_collision_probe.md
Name: maze_collision_probe

Overview:
- Initiator on the maze ROM interface. A maze ROM takes a 13-bit pixel index and returns a 16-bit RGB565 colour one clock later.
- On request, the block scans a BOX_W x BOX_H player footprint at a candidate position on the 96x64 OLED maze.
- Reports whether any footprint pixel is wall, the first wall pixel in raster order, and the wall-pixel count.
- Sits between player-movement logic and the maze ROM; movement commits only when hit=0.

Parameters:
WIDTH, 96, maze width in pixels
HEIGHT, 64, maze height in pixels
BOX_W, 3, footprint width in pixels (1..8)
BOX_H, 3, footprint height in pixels (1..8)
WALL_COLOR, 16'hFFFF, colour value that marks a wall pixel
IDX_W, 13, ROM index width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  request pulse; accepted only in IDLE
pos_x  in  7  footprint top-left x, latched on accepted start
pos_y  in  6  footprint top-left y, latched on accepted start
maze_index  out  IDX_W  ROM pixel index, registered
maze_data  in  16  ROM colour; valid the cycle after maze_index is presented
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when results are valid
hit  out  1  at least one footprint pixel is wall
hit_x  out  7  x of first wall pixel (raster order)
hit_y  out  6  y of first wall pixel
hit_count  out  7  number of wall pixels in the footprint

Behaviour:
Reset:
- All outputs 0: maze_index, busy, done, hit, hit_x, hit_y, hit_count.
- FSM goes to IDLE; scan counters cleared.
- Reset mid-scan aborts with no done pulse. Results are cleared, not held.

FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: start=1 latches pos_x/pos_y, clears hit/hit_x/hit_y/hit_count, zeroes column/row counters (cx, cy), and goes to SCAN. start=0 stays in IDLE.
- SCAN: each cycle registers the pixel (pos_x+cx, pos_y+cy) and advances cx. When cx wraps at BOX_W-1, cx returns to 0 and cy increments. After pixel (BOX_W-1, BOX_H-1) is issued, goes to DRAIN. Exactly BOX_W*BOX_H cycles.
- DRAIN: one cycle to evaluate the final pixel, then goes to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Results hold from DONE until the next accepted start.
- start in SCAN, DRAIN or DONE is ignored, not queued.

Timing:
- Accepted start at edge N gives busy=1 from cycle N+1 and done high in cycle N+BOX_W*BOX_H+2.
- Default footprint: start-to-done is 11 cycles.

Index arithmetic:
- maze_index = y*WIDTH + x, computed at full width and truncated to IDX_W.
- x and y are computed 1 bit wider than pos_x/pos_y so no wrap occurs.

Evaluation pipeline:
- A 1-cycle delayed copy of (x, y, in_bounds, valid) is paired with maze_data.
- A pixel is wall if it is out of bounds (x>=WIDTH or y>=HEIGHT), or if maze_data==WALL_COLOR when in bounds.
- For out-of-bounds pixels, maze_index holds its previous value and maze_data is ignored.

Result update on each wall pixel:
- hit_count increments (saturates at 127).
- On the first wall pixel only, hit is set and hit_x/hit_y capture its coordinates; later wall pixels do not overwrite them.

Edge cases:
- Only exact WALL_COLOR is wall. Any other colour, including partial values such as 16'h001F, is floor.
- pos on the last row/column is legal; the overflow part of the footprint counts as wall.

Test Plan:
Bench maze ROM model: registered 1-cycle ROM; pixels with x<=2, x>=93, y<=2 or y>=61 return 16'hFFFF, all others 16'h0000. Bench checks the index sequence and the 1-cycle data alignment.
1. Floor probe: start with pos (10,10) -> indices 970,971,972,1066,1067,1068,1162,1163,1164 issued in order; done exactly 11 cycles after start; hit=0, hit_count=0.
2. Left wall: pos (1,20) -> hit=1, hit_x=1, hit_y=20, hit_count=6.
3. Out of bounds: pos (95,63) -> hit=1, hit_x=95, hit_y=63, hit_count=9; maze_index never exceeds 6143.
4. Colour match: ROM returns 16'h001F at (11,11) and pos (10,10) -> hit=0. The same test with 16'hFFFF at (11,11) -> hit=1, hit_x=11, hit_y=11, hit_count=1.
5. Start during scan: second start pulse 4 cycles after the first, with different pos -> ignored; a single done pulse; results match the first pos.
6. Reset mid-scan: reset asserted at cycle 5 of a pos (1,20) scan -> next cycle busy=0, hit=0, hit_count=0, no done pulse. A new start at pos (10,10) then completes normally with hit=0.
